// File: rtl/sha256_compress_rounds.sv
// sha256_compress_rounds: SHA-256 compression engine that fetches W[0..63]
// from the W-schedule generator, runs 64 rounds on a..h and adds the result
// to the chaining value.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   start             one-cycle compress request, honoured only in IDLE
//   hash_in           chaining value H0..H7 (H0 in [255:224])
//   iv_sel            (SHA256_IV_SEL_EN only) load the FIPS 180-4 IV instead
//   w_reg_rdy         generator is serving W words
//   w_reg_data        W word from the generator, valid W_LAT cycles after read
//   local_go_sig      go to the generator, high from start acceptance to DONE
//   w_reg_read        one-cycle read pulse per W word
//   w_reg_addr        index t of the requested W word
//   busy              high in every state except IDLE
//   done              one-cycle pulse, digest_out valid from this cycle
//   digest_out        H + final a..h, held until the next compression ends
//
// Optional feature macro: SHA256_IV_SEL_EN (adds iv_sel).

module sha256_compress_rounds #(
  parameter int unsigned W_LAT = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*WIDTH-1:0]   hash_in,
`ifdef SHA256_IV_SEL_EN
  input  logic                 iv_sel,
`endif
  input  logic                 w_reg_rdy,
  input  logic [WIDTH-1:0]     w_reg_data,
  output logic                 local_go_sig,
  output logic                 w_reg_read,
  output logic [5:0]           w_reg_addr,
  output logic                 busy,
  output logic                 done,
  output logic [8*WIDTH-1:0]   digest_out
);

  localparam int unsigned CNT_W = (W_LAT > 1) ? $clog2(W_LAT) : 1;
  localparam int unsigned T_W   = 6;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_FEED   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [WIDTH-1:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WIDTH - n));
  endfunction

  logic [2:0]               state_q,  state_d;
  logic [T_W-1:0]           t_q,      t_d;
  logic [CNT_W-1:0]         wcnt_q,   wcnt_d;
  logic [7:0][WIDTH-1:0]    v_q,      v_d;       // [7]=a ... [0]=h
  logic [7:0][WIDTH-1:0]    hreg_q,   hreg_d;    // [7]=H0 ... [0]=H7
  logic [WIDTH-1:0]         w_hold_q, w_hold_d;
  logic [8*WIDTH-1:0]       digest_q, digest_d;
  logic                     go_q,     go_d;
  logic                     busy_q,   busy_d;
  logic                     done_q,   done_d;
  logic [7:0][WIDTH-1:0]    init_c;
  logic [WIDTH-1:0]         s0_c, s1_c, ch_c, maj_c, t1_c, t2_c;

  // Initial chaining value selected at start acceptance
`ifdef SHA256_IV_SEL_EN
  localparam logic [8*WIDTH-1:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  assign init_c = iv_sel ? IV : hash_in;
`else
  assign init_c = hash_in;
`endif

  // Round function on the current working registers
  always_comb begin
    s1_c  = rotr(v_q[3], 6) ^ rotr(v_q[3], 11) ^ rotr(v_q[3], 25);
    ch_c  = (v_q[3] & v_q[2]) ^ (~v_q[3] & v_q[1]);
    s0_c  = rotr(v_q[7], 2) ^ rotr(v_q[7], 13) ^ rotr(v_q[7], 22);
    maj_c = (v_q[7] & v_q[6]) ^ (v_q[7] & v_q[5]) ^ (v_q[6] & v_q[5]);
    t1_c  = v_q[0] + s1_c + ch_c + K_TAB[t_q] + w_hold_q;
    t2_c  = s0_c + maj_c;
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    wcnt_d   = wcnt_q;
    v_d      = v_q;
    hreg_d   = hreg_q;
    w_hold_d = w_hold_q;
    digest_d = digest_q;
    go_d     = go_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hreg_d  = init_c;
          v_d     = init_c;
          t_d     = '0;
          go_d    = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (w_reg_rdy) state_d = S_REQ;
      end
      S_REQ: begin
        if (w_reg_rdy) begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q == CNT_W'(W_LAT - 1)) begin
          w_hold_d = w_reg_data;
          state_d  = S_ROUND;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_ROUND: begin
        v_d = {t1_c + t2_c, v_q[7], v_q[6], v_q[5], v_q[4] + t1_c, v_q[3], v_q[2], v_q[1]};
        if (t_q == T_W'(63)) begin
          state_d = S_FEED;
        end else begin
          t_d     = t_q + 1'b1;
          state_d = S_REQ;
        end
      end
      S_FEED: begin
        for (int i = 0; i < 8; i++) begin
          digest_d[i*WIDTH +: WIDTH] = hreg_q[i] + v_q[i];
        end
        go_d    = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      wcnt_q   <= '0;
      v_q      <= '0;
      hreg_q   <= '0;
      w_hold_q <= '0;
      digest_q <= '0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      wcnt_q   <= wcnt_d;
      v_q      <= v_d;
      hreg_q   <= hreg_d;
      w_hold_q <= w_hold_d;
      digest_q <= digest_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Read pulse must coincide with the REQ cycle the generator latency is
  // measured from, so it is decoded from the state register and w_reg_rdy.
  assign w_reg_read   = (state_q == S_REQ) & w_reg_rdy;
  assign w_reg_addr   = t_q;
  assign local_go_sig = go_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign digest_out   = digest_q;

endmodule

// File: tb/tb_sha256_compress_rounds.sv
// Testbench for sha256_compress_rounds: W-generator model plus a reference
// SHA-256 compression function; known-answer and random blocks.

module tb_sha256_compress_rounds;

  localparam int unsigned W_LAT = 2;
  localparam int M_NORM  = 0;
  localparam int M_STALL = 1;
  localparam int M_SPUR  = 2;
  localparam int M_RST   = 3;

  localparam logic [255:0] IV        = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2    = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clock;
  logic         reset;
  logic         start;
  logic [255:0] hash_in;
`ifdef SHA256_IV_SEL_EN
  logic         iv_sel;
`endif
  logic         w_reg_rdy;
  logic [31:0]  w_reg_data;
  logic         local_go_sig;
  logic         w_reg_read;
  logic [5:0]   w_reg_addr;
  logic         busy;
  logic         done;
  logic [255:0] digest_out;
  logic         stall;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gidx = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int rd_in_stall = 0;
  logic [31:0] wsch [64];
  logic [31:0] s1r, s2r;
  logic [5:0]  reads [$];
  int          rd_cyc [$];

  sha256_compress_rounds #(.W_LAT(W_LAT), .WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .hash_in      (hash_in),
`ifdef SHA256_IV_SEL_EN
    .iv_sel       (iv_sel),
`endif
    .w_reg_rdy    (w_reg_rdy),
    .w_reg_data   (w_reg_data),
    .local_go_sig (local_go_sig),
    .w_reg_read   (w_reg_read),
    .w_reg_addr   (w_reg_addr),
    .busy         (busy),
    .done         (done),
    .digest_out   (digest_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Generator serves W while go is high, unless the bench forces a stall
  assign w_reg_rdy = local_go_sig & ~stall;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] y;
    y = {x, x} >> n;
    return y[31:0];
  endfunction

  function automatic void sched(input logic [511:0] blk, output logic [31:0] w [64]);
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    sched(blk, w);
    for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
    return r;
  endfunction

  // Generator model and monitor: data appears W_LAT cycles after each read
  always @(negedge clock) begin
    cyc = cyc + 1;
    w_reg_data = s2r;
    s2r = s1r;
    s1r = 32'hdeadbeef;
    if (local_go_sig !== 1'b1) gidx = 0;
    if (w_reg_read === 1'b1) begin
      reads.push_back(w_reg_addr);
      rd_cyc.push_back(cyc);
      if (stall) rd_in_stall++;
      s1r = wsch[gidx % 64];
      gidx++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic do_run(input logic [255:0] h, input logic [511:0] blk, input int mode,
                        output logic [255:0] dig, output int lat, output bit to);
    bit spur_done;
    int c;
    sched(blk, wsch);
    reads.delete();
    rd_cyc.delete();
    done_cnt = 0; done_cyc = -1; rd_in_stall = 0; spur_done = 0;
    dig = '0; lat = -1; to = 1'b1; stall = 1'b0;
    @(posedge clock); #1;
    hash_in = h;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      start = 1'b0;
      if (mode == M_STALL && rd_cyc.size() >= 20) begin
        c = rd_cyc[19];
        if (cyc + 1 == c + 4)  stall = 1'b1;
        if (cyc + 1 == c + 14) stall = 1'b0;
      end
      if (mode == M_SPUR && !spur_done && reads.size() == 31) begin
        start = 1'b1;
        spur_done = 1'b1;
      end
      if (mode == M_RST && reads.size() == 41) begin
        reset = 1'b1;
        to = 1'b0;
        break;
      end
      if (done === 1'b1) begin
        dig = digest_out;
        if (mode == M_SPUR) start = 1'b1;
        to = 1'b0;
        break;
      end
      @(posedge clock); #1;
    end
    if (mode != M_RST) begin
      @(posedge clock); #1;
      start = 1'b0;
      stall = 1'b0;
      lat = done_cyc - ((rd_cyc.size() > 0) ? rd_cyc[0] : 0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (local_go_sig !== 1'b0) begin errors++; $display("FAIL reset_go got %b want 0", local_go_sig); end
    checks++; if (w_reg_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", w_reg_read); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (w_reg_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", w_reg_addr); end
    checks++; if (digest_out !== 256'h0) begin errors++; $display("FAIL reset_digest got %h want 0", digest_out); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_abc();
    logic [255:0] d; int lat; bit to;
    do_run(IV, ABC_BLK, M_NORM, d, lat, to);
    checks++; if (to) begin errors++; $display("FAIL abc_timeout got no done want done"); end
    checks++; if (d !== ABC_DIG) begin errors++; $display("FAIL abc_digest got %h want %h", d, ABC_DIG); end
    checks++; if (lat !== 257) begin errors++; $display("FAIL abc_latency got %0d want 257", lat); end
    repeat (4) @(posedge clock); #1;
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL abc_done_count got %0d want 1", done_cnt); end
    checks++; if (digest_out !== ABC_DIG) begin errors++; $display("FAIL abc_digest_held got %h want %h", digest_out, ABC_DIG); end
    checks++; if (busy !== 1'b0 || local_go_sig !== 1'b0) begin errors++; $display("FAIL abc_idle got busy=%b go=%b want 0 0", busy, local_go_sig); end
  endtask

  task automatic test_empty();
    logic [255:0] d; int lat; bit to; int bad;
    do_run(IV, EMPTY_BLK, M_NORM, d, lat, to);
    checks++; if (to) begin errors++; $display("FAIL empty_timeout got no done want done"); end
    checks++; if (d !== EMPTY_DIG) begin errors++; $display("FAIL empty_digest got %h want %h", d, EMPTY_DIG); end
    checks++; if (reads.size() !== 64) begin errors++; $display("FAIL empty_read_count got %0d want 64", reads.size()); end
    bad = 0;
    for (int i = 0; i < reads.size(); i++) if (reads[i] !== 6'(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL empty_addr_order got %0d out-of-order want 0", bad); end
  endtask

  task automatic test_two_block();
    logic [255:0] d1, d2, e1; int lat; bit to;
    e1 = ref_compress(IV, TWO_B1);
    do_run(IV, TWO_B1, M_NORM, d1, lat, to);
    checks++; if (to || d1 !== e1) begin errors++; $display("FAIL two_blk1 got %h want %h", d1, e1); end
    do_run(d1, TWO_B2, M_NORM, d2, lat, to);
    checks++; if (to || d2 !== TWO_DIG) begin errors++; $display("FAIL two_blk2 got %h want %h", d2, TWO_DIG); end
  endtask

  task automatic test_stall();
    logic [255:0] d; int lat; bit to;
    do_run(IV, ABC_BLK, M_STALL, d, lat, to);
    checks++; if (to || d !== ABC_DIG) begin errors++; $display("FAIL stall_digest got %h want %h", d, ABC_DIG); end
    checks++; if (lat !== 267) begin errors++; $display("FAIL stall_latency got %0d want 267", lat); end
    checks++; if (rd_in_stall !== 0) begin errors++; $display("FAIL stall_read_while_low got %0d want 0", rd_in_stall); end
    checks++; if (reads.size() !== 64) begin errors++; $display("FAIL stall_read_count got %0d want 64", reads.size()); end
  endtask

  task automatic test_spurious();
    logic [255:0] d; int lat; bit to;
    do_run(IV, ABC_BLK, M_SPUR, d, lat, to);
    checks++; if (to || d !== ABC_DIG) begin errors++; $display("FAIL spur_digest got %h want %h", d, ABC_DIG); end
    repeat (4) @(posedge clock); #1;
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL spur_done_count got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_restart got busy=%b want 0", busy); end
    checks++; if (reads.size() !== 64) begin errors++; $display("FAIL spur_read_count got %0d want 64", reads.size()); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] d; int lat; bit to;
    do_run(IV, ABC_BLK, M_RST, d, lat, to);
    #1;
    checks++; if (to) begin errors++; $display("FAIL rstmid_timeout got no t=40 want t=40"); end
    checks++; if (local_go_sig !== 1'b0) begin errors++; $display("FAIL rstmid_go got %b want 0", local_go_sig); end
    checks++; if (w_reg_read !== 1'b0) begin errors++; $display("FAIL rstmid_read got %b want 0", w_reg_read); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_busy_done got %b%b want 00", busy, done); end
    checks++; if (w_reg_addr !== 6'd0) begin errors++; $display("FAIL rstmid_addr got %0d want 0", w_reg_addr); end
    checks++; if (digest_out !== 256'h0) begin errors++; $display("FAIL rstmid_digest got %h want 0", digest_out); end
    @(negedge clock);
    reset = 1'b0;
    do_run(IV, ABC_BLK, M_NORM, d, lat, to);
    checks++; if (to || d !== ABC_DIG) begin errors++; $display("FAIL rstmid_rerun got %h want %h", d, ABC_DIG); end
  endtask

  task automatic test_random();
    logic [255:0] h, d, e; logic [511:0] blk; int lat; bit to;
    for (int n = 0; n < 3; n++) begin
      for (int j = 0; j < 8; j++)  h[32*j +: 32] = $urandom();
      for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom();
      e = ref_compress(h, blk);
      do_run(h, blk, M_NORM, d, lat, to);
      checks++; if (to || d !== e) begin errors++; $display("FAIL random_digest[%0d] got %h want %h", n, d, e); end
      checks++; if (lat !== 257) begin errors++; $display("FAIL random_latency[%0d] got %0d want 257", n, lat); end
    end
  endtask

`ifdef SHA256_IV_SEL_EN
  task automatic test_iv_sel();
    logic [255:0] d; int lat; bit to;
    iv_sel = 1'b1;
    do_run({256{1'b1}}, ABC_BLK, M_NORM, d, lat, to);
    iv_sel = 1'b0;
    checks++; if (to || d !== ABC_DIG) begin errors++; $display("FAIL iv_sel_digest got %h want %h", d, ABC_DIG); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    hash_in = '0;
    stall = 1'b0;
    s1r = '0;
    s2r = '0;
    w_reg_data = '0;
`ifdef SHA256_IV_SEL_EN
    iv_sel = 1'b0;
`endif
    test_reset();
    test_abc();
    test_empty();
    test_two_block();
    test_stall();
    test_spurious();
    test_reset_mid();
    test_random();
`ifdef SHA256_IV_SEL_EN
    test_iv_sel();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
